// File: rtl/fft_stream_controller.sv
// fft_stream_controller
//   Streams sample pairs into a cf_fft style core running on global_clk with a
//   periodic clock-enable strobe, marks frame starts with core_sync, and turns
//   the core's output frame into an indexed valid stream.
//
// Ports
//   global_clk, reset            clock, async active-high reset
//   start, continuous            frame request (level) and back-to-back mode
//   in_valid/in_ready,
//   in_data_0/in_data_1          input pair handshake (accepted only on ticks)
//   core_enable                  enable strobe to the core (one cycle per CLK_DIV)
//   core_sync, core_data_0/1     registered drive into the core
//   core_sync_o, core_out_0/1    core outputs
//   out_valid, out_data_0/1,
//   out_index, out_last          captured output pair stream
//   busy                         feeding or capturing
//   underrun, overlap            sticky error flags
//
// Feed FSM
//   state   | meaning
//   IDLE    | no frame in progress; waits for start on a tick
//   FEED    | one pair per tick into the core, P pairs per frame
module fft_stream_controller #(
  parameter int IN_WIDTH    = 8,
  parameter int CORE_WIDTH  = 16,
  parameter int OUT_WIDTH   = 8,
  parameter int LOG2_POINTS = 8,
  parameter int CLK_DIV     = 15
) (
  input  logic                   global_clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   continuous,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_WIDTH-1:0]    in_data_0,
  input  logic [IN_WIDTH-1:0]    in_data_1,
  output logic                   core_enable,
  output logic                   core_sync,
  output logic [CORE_WIDTH-1:0]  core_data_0,
  output logic [CORE_WIDTH-1:0]  core_data_1,
  input  logic                   core_sync_o,
  input  logic [CORE_WIDTH-1:0]  core_out_0,
  input  logic [CORE_WIDTH-1:0]  core_out_1,
  output logic                   out_valid,
  output logic [OUT_WIDTH-1:0]   out_data_0,
  output logic [OUT_WIDTH-1:0]   out_data_1,
  output logic [LOG2_POINTS-2:0] out_index,
  output logic                   out_last,
  output logic                   busy,
  output logic                   underrun,
  output logic                   overlap
);

  localparam int CNT_W = LOG2_POINTS - 1;
  localparam int P     = 2 ** CNT_W;
  localparam int PAD   = CORE_WIDTH - IN_WIDTH;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0] LAST_IDX     = CNT_W'(P - 1);
  localparam logic [CNT_W-1:0] PRE_LAST_IDX = CNT_W'(P - 2);
  localparam logic [DIV_W-1:0] DIV_TOP      = DIV_W'(CLK_DIV - 1);

  typedef enum logic {ST_IDLE, ST_FEED} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] feed_cnt, feed_cnt_nxt;
  logic             cont_q, cont_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             cap_active;

  // Enable divider
  assign tick        = (div_cnt == DIV_TOP);
  assign core_enable = tick;

  always_ff @(posedge global_clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Feed FSM: state register
  always_ff @(posedge global_clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      feed_cnt <= '0;
      cont_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      feed_cnt <= feed_cnt_nxt;
      cont_q   <= cont_nxt;
    end
  end

  // Feed FSM: next state and handshake. feed_cnt wraps to 0 by width on the
  // last pair, which is exactly the restart value for a continuous frame.
  always_comb begin
    state_nxt    = state;
    feed_cnt_nxt = feed_cnt;
    cont_nxt     = cont_q;
    in_ready     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tick && start) begin
          state_nxt    = ST_FEED;
          feed_cnt_nxt = '0;
          cont_nxt     = continuous;
        end
      end
      ST_FEED: begin
        in_ready = tick;
        if (tick) begin
          feed_cnt_nxt = feed_cnt + 1'b1;
          if (feed_cnt == LAST_IDX) begin
            if (cont_q && start) begin
              cont_nxt = continuous;
            end else begin
              state_nxt = ST_IDLE;
            end
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Core drive: updated only on ticks so the core sees stable inputs between
  // enables. A missing pair feeds zeros rather than stalling the frame.
  always_ff @(posedge global_clk or posedge reset) begin
    if (reset) begin
      core_sync   <= 1'b0;
      core_data_0 <= '0;
      core_data_1 <= '0;
      underrun    <= 1'b0;
    end else if (tick) begin
      if (state == ST_FEED) begin
        core_sync <= (feed_cnt == '0);
        if (in_valid) begin
          core_data_0 <= CORE_WIDTH'(in_data_0) << PAD;
          core_data_1 <= CORE_WIDTH'(in_data_1) << PAD;
        end else begin
          core_data_0 <= '0;
          core_data_1 <= '0;
          underrun    <= 1'b1;
        end
      end else begin
        core_sync <= 1'b0;
      end
    end
  end

  // Capture: core_sync_o always (re)starts a frame at index 0; a restart
  // while a frame is still being collected is flagged as overlap.
  always_ff @(posedge global_clk or posedge reset) begin
    if (reset) begin
      cap_active <= 1'b0;
      out_valid  <= 1'b0;
      out_index  <= '0;
      out_data_0 <= '0;
      out_data_1 <= '0;
      overlap    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (tick) begin
        if (core_sync_o) begin
          if (cap_active) begin
            overlap <= 1'b1;
          end
          cap_active <= 1'b1;
          out_index  <= '0;
          out_valid  <= 1'b1;
          out_data_0 <= core_out_0[CORE_WIDTH-1 -: OUT_WIDTH];
          out_data_1 <= core_out_1[CORE_WIDTH-1 -: OUT_WIDTH];
        end else if (cap_active) begin
          out_index  <= out_index + 1'b1;
          out_valid  <= 1'b1;
          out_data_0 <= core_out_0[CORE_WIDTH-1 -: OUT_WIDTH];
          out_data_1 <= core_out_1[CORE_WIDTH-1 -: OUT_WIDTH];
          if (out_index == PRE_LAST_IDX) begin
            cap_active <= 1'b0;
          end
        end
      end
    end
  end

  assign out_last = out_valid && (out_index == LAST_IDX);
  assign busy     = (state != ST_IDLE) || cap_active;

endmodule
